// File: rtl/i2c_slave_lcd_frame_writer_pkg.sv
// Shared LCD command bytes, state encodings and sizing helpers for the
// HD44780 frame writer and its bus write-cycle timer.
package i2c_slave_lcd_frame_writer_pkg;

    localparam logic [7:0] CMD_FUNC_8BIT_2LINE = 8'h38;
    localparam logic [7:0] CMD_DISP_ON         = 8'h0C;
    localparam logic [7:0] CMD_CLEAR           = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC       = 8'h06;
    localparam logic [7:0] CMD_LINE1           = 8'h80;
    localparam logic [7:0] CMD_LINE2           = 8'hC0;

    localparam int INIT_CMDS = 6;

    typedef enum logic [2:0] {
        ST_PWRUP_WAIT, ST_INIT, ST_IDLE, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2
    } top_state_e;

    typedef enum logic [1:0] {WC_IDLE, WC_SETUP, WC_PULSE, WC_HOLD} wc_phase_e;

    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Power-up command sequence; the function set is repeated three times.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return CMD_FUNC_8BIT_2LINE;
            3'd3:             return CMD_DISP_ON;
            3'd4:             return CMD_CLEAR;
            default:          return CMD_ENTRY_INC;
        endcase
    endfunction

endpackage

// File: rtl/i2c_slave_lcd_write_cycle.sv
// One LCD bus write: SETUP (E low), PULSE (E high), HOLD (E low) with a
// long hold for the clear command. done_o marks the last hold clock.
module i2c_slave_lcd_write_cycle
    import i2c_slave_lcd_frame_writer_pkg::*;
#(
    parameter int T_SETUP  = 2,
    parameter int T_EPULSE = 12,
    parameter int T_CMD    = 2000,
    parameter int T_CLEAR  = 82000,
    parameter int CW       = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] byte_i,
    input  logic       long_hold_i,
    output logic       lcd_e_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_db_o,
    output logic       done_o
);
    localparam logic [CW-1:0] SETUP_LAST = CW'(clamp1(T_SETUP) - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(clamp1(T_EPULSE) - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(clamp1(T_CMD) - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(clamp1(T_CLEAR) - 1);

    wc_phase_e     phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d, long_q, long_d;
    logic [7:0]    db_q, db_d;
    logic [CW-1:0] hold_last;

    assign hold_last = long_q ? CLEAR_LAST : CMD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= WC_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
            db_q    <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
            db_q    <= db_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        rs_d    = rs_q;
        long_d  = long_q;
        db_d    = db_q;
        done_o  = 1'b0;
        case (phase_q)
            WC_IDLE:  cnt_d = '0;
            WC_SETUP: if (cnt_q == SETUP_LAST) begin phase_d = WC_PULSE; cnt_d = '0; end
            WC_PULSE: if (cnt_q == PULSE_LAST) begin phase_d = WC_HOLD;  cnt_d = '0; end
            WC_HOLD:  if (cnt_q == hold_last) begin
                phase_d = WC_IDLE;
                cnt_d   = '0;
                done_o  = 1'b1;
            end
            default:  phase_d = WC_IDLE;
        endcase
        // A start in the done cycle chains the next write with no gap clock.
        if (start_i) begin
            phase_d = WC_SETUP;
            cnt_d   = '0;
            rs_d    = rs_i;
            db_d    = byte_i;
            long_d  = long_hold_i;
        end
    end

    assign lcd_e_o  = (phase_q == WC_PULSE);
    assign lcd_rs_o = rs_q;
    assign lcd_db_o = db_q;

endmodule

// File: rtl/i2c_slave_lcd_frame_writer.sv
// Drives a 16x2 HD44780 LCD: power-up wait, init commands, then writes each
// accepted 32-char frame as 80, line 1, C0, line 2.
module i2c_slave_lcd_frame_writer
    import i2c_slave_lcd_frame_writer_pkg::*;
#(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 2,
    parameter int T_EPULSE  = 12,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] lcd_data_i,
    input  logic         frame_valid_i,
    output logic         frame_ready_o,
    output logic         frame_done_o,
    output logic         init_done_o,
    output logic         lcd_e_o,
    output logic         lcd_rs_o,
    output logic         lcd_rw_o,
    output logic [7:0]   lcd_db_o
);
    localparam int MAXP = max2(max2(clamp1(T_POWERUP), clamp1(T_CLEAR)),
                               max2(max2(clamp1(T_CMD), clamp1(T_SETUP)), clamp1(T_EPULSE)));
    localparam int CW = $clog2(MAXP) + 1;
    localparam logic [CW-1:0] PWR_LAST = CW'(clamp1(T_POWERUP) - 1);

    top_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    idx_q, idx_d, idx_inc;
    logic [255:0]  frame_q, frame_d;
    logic          init_done_q, init_done_d;
    logic          wc_start, wc_rs, wc_done, last_done, ready;
    logic [7:0]    wc_byte, next_char;

    assign idx_inc   = idx_q + 5'd1;
    assign next_char = frame_q[{idx_inc, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PWRUP_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        init_done_d = init_done_q;
        wc_start    = 1'b0;
        wc_rs       = 1'b0;
        wc_byte     = CMD_LINE1;
        last_done   = 1'b0;
        case (state_q)
            ST_PWRUP_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    state_d  = ST_INIT;
                    cnt_d    = '0;
                    idx_d    = '0;
                    wc_start = 1'b1;
                    wc_byte  = init_cmd(3'd0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_INIT: if (wc_done) begin
                if (idx_q == 5'(INIT_CMDS - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    last_done   = 1'b1;
                end else begin
                    idx_d    = idx_inc;
                    wc_start = 1'b1;
                    wc_byte  = init_cmd(idx_inc[2:0]);
                end
            end
            ST_ADDR1: if (wc_done) begin
                state_d  = ST_LINE1;
                idx_d    = 5'd0;
                wc_start = 1'b1;
                wc_rs    = 1'b1;
                wc_byte  = frame_q[7:0];
            end
            ST_LINE1: if (wc_done) begin
                wc_start = 1'b1;
                if (idx_q == 5'd15) begin
                    state_d = ST_ADDR2;
                    wc_byte = CMD_LINE2;
                end else begin
                    idx_d   = idx_inc;
                    wc_rs   = 1'b1;
                    wc_byte = next_char;
                end
            end
            ST_ADDR2: if (wc_done) begin
                state_d  = ST_LINE2;
                idx_d    = 5'd16;
                wc_start = 1'b1;
                wc_rs    = 1'b1;
                wc_byte  = frame_q[135:128];
            end
            ST_LINE2: if (wc_done) begin
                // Char 31 ends the frame; the index never advances past it.
                if (idx_q == 5'd31) begin
                    state_d   = ST_IDLE;
                    last_done = 1'b1;
                end else begin
                    idx_d    = idx_inc;
                    wc_start = 1'b1;
                    wc_rs    = 1'b1;
                    wc_byte  = next_char;
                end
            end
            ST_IDLE: ;
            default: state_d = ST_PWRUP_WAIT;
        endcase
        ready = (state_q == ST_IDLE) || last_done;
        if (ready && frame_valid_i) begin
            frame_d  = lcd_data_i;
            state_d  = ST_ADDR1;
            wc_start = 1'b1;
            wc_rs    = 1'b0;
            wc_byte  = CMD_LINE1;
        end
    end

    i2c_slave_lcd_write_cycle #(
        .T_SETUP (T_SETUP),
        .T_EPULSE(T_EPULSE),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR),
        .CW      (CW)
    ) u_wc (
        .clk        (clk),
        .rst        (rst),
        .start_i    (wc_start),
        .rs_i       (wc_rs),
        .byte_i     (wc_byte),
        .long_hold_i(!wc_rs && (wc_byte == CMD_CLEAR)),
        .lcd_e_o    (lcd_e_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_db_o   (lcd_db_o),
        .done_o     (wc_done)
    );

    assign frame_ready_o = ready;
    assign frame_done_o  = (state_q == ST_LINE2) && wc_done && (idx_q == 5'd31);
    assign init_done_o   = init_done_q || ((state_q == ST_INIT) && last_done);
    assign lcd_rw_o      = 1'b0;

endmodule

// File: tb/tb_i2c_slave_lcd_frame_writer.sv
// Directed bench for the LCD frame writer with short timing parameters
// (normal write 7 clocks, clear 11 clocks, power-up wait 10 clocks).
module tb_i2c_slave_lcd_frame_writer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] lcd_data = '0;
    logic         frame_valid = 1'b0;
    logic         frame_ready, frame_done, init_done;
    logic         lcd_e, lcd_rs, lcd_rw;
    logic [7:0]   lcd_db;

    i2c_slave_lcd_frame_writer #(
        .T_POWERUP(10), .T_SETUP(1), .T_EPULSE(2), .T_CMD(4), .T_CLEAR(8)
    ) dut (
        .clk(clk), .rst(rst), .lcd_data_i(lcd_data), .frame_valid_i(frame_valid),
        .frame_ready_o(frame_ready), .frame_done_o(frame_done), .init_done_o(init_done),
        .lcd_e_o(lcd_e), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_db_o(lcd_db)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { logic rs; logic [7:0] db; int cyc; } ev_t;
    typedef struct { logic [7:0] db; int off; } init_t;

    ev_t  ev_q[$];
    logic e_prev = 1'b0;
    int   rw_bad = 0;
    int   n_tests = 0, n_fail = 0;

    // Logs every E rising edge with the bus contents and the cycle it was seen.
    always @(negedge clk) begin
        ev_t e;
        if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
            e.rs = lcd_rs; e.db = lcd_db; e.cyc = cyc;
            ev_q.push_back(e);
        end
        e_prev = lcd_e;
        if (!rst && lcd_rw !== 1'b0) rw_bad++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_frame(input string l1, input string l2);
        logic [255:0] f;
        for (int i = 0; i < 16; i++) begin
            f[8*i +: 8]      = (i < l1.len()) ? l1[i] : 8'hFE;
            f[8*(16+i) +: 8] = (i < l2.len()) ? l2[i] : 8'hFE;
        end
        return f;
    endfunction

    init_t init_tab[6];

    // Rise offsets from the first rst-low cycle: 10 power-up, 1 setup, then 7 per write, 11 for clear.
    task automatic run_init(input int k);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("init_done_cycle", cyc, k + 55);
        check("init_ready", frame_ready, 1'b1);
        check("init_write_count", ev_q.size(), 6);
        for (int i = 0; i < 6 && i < ev_q.size(); i++) begin
            check($sformatf("init%0d_rs", i), ev_q[i].rs, 1'b0);
            check($sformatf("init%0d_db", i), ev_q[i].db, init_tab[i].db);
            check($sformatf("init%0d_cyc", i), ev_q[i].cyc, k + init_tab[i].off);
        end
    endtask

    // Builds the 34-write table for one frame and compares it to the log.
    task automatic check_frame(input string tag, input logic [255:0] f, input int a, input int base);
        ev_t exp_w[34];
        for (int j = 0; j < 34; j++) begin
            exp_w[j].rs  = (j != 0) && (j != 17);
            exp_w[j].db  = (j == 0) ? 8'h80 : (j == 17) ? 8'hC0 :
                           (j < 17) ? f[8*(j-1) +: 8] : f[8*(j-2) +: 8];
            exp_w[j].cyc = a + 2 + 7*j;
        end
        for (int j = 0; j < 34; j++) begin
            if (base + j >= ev_q.size()) begin
                check($sformatf("%s_w%0d_missing", tag, j), ev_q.size(), base + 34);
                break;
            end
            check($sformatf("%s_w%0d_rs", tag, j), ev_q[base+j].rs, exp_w[j].rs);
            check($sformatf("%s_w%0d_db", tag, j), ev_q[base+j].db, exp_w[j].db);
            check($sformatf("%s_w%0d_cyc", tag, j), ev_q[base+j].cyc, exp_w[j].cyc);
        end
    endtask

    initial begin
        logic [255:0] fa, fb;
        int k, a, b, n, rdy_bad, done_bad;
        init_tab[0] = '{8'h38, 11}; init_tab[1] = '{8'h38, 18}; init_tab[2] = '{8'h38, 25};
        init_tab[3] = '{8'h0C, 32}; init_tab[4] = '{8'h01, 39}; init_tab[5] = '{8'h06, 50};
        fa = mk_frame("MAIN MENU", "Display Master");
        fb = {32{8'hFE}};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_e", lcd_e, 1'b0);
        check("rst_rs", lcd_rs, 1'b0);
        check("rst_rw", lcd_rw, 1'b0);
        check("rst_db", lcd_db, 8'h00);
        check("rst_ready", frame_ready, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_init_done", init_done, 1'b0);

        // Valid is offered throughout init and must be ignored until ready.
        lcd_data = fa; frame_valid = 1'b1; rst = 1'b0;
        k = cyc; ev_q.delete();
        run_init(k);
        a = cyc;
        ev_q.delete();

        rdy_bad = 0; done_bad = 0;
        for (int t = 1; t < 238; t++) begin
            @(negedge clk);
            if (frame_ready !== 1'b0) rdy_bad++;
            if (frame_done !== 1'b0) done_bad++;
            if (t == 50) begin lcd_data = fb; frame_valid = 1'b0; end
            if (t == 60) frame_valid = 1'b1;
            if (t == 70) frame_valid = 1'b0;
            if (t == 100) frame_valid = 1'b1;
        end
        check("busy_ready_low", rdy_bad, 0);
        check("busy_no_done", done_bad, 0);
        @(negedge clk);
        check("A_done_at_238", frame_done, 1'b1);
        check("A_done_ready", frame_ready, 1'b1);
        b = cyc;
        @(negedge clk);
        check("done_one_cycle", frame_done, 1'b0);
        check("B_accepted", frame_ready, 1'b0);
        frame_valid = 1'b0;

        n = 0;
        while (frame_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("B_done_cycle", cyc, b + 238);
        check_frame("A", fa, a, 0);
        check_frame("B", fb, b, 34);
        repeat (20) @(negedge clk);
        check("no_extra_writes", ev_q.size(), 68);
        check("idle_db_hold", lcd_db, 8'hFE);
        check("idle_ready", frame_ready, 1'b1);
        check("idle_e_low", lcd_e, 1'b0);

        // Reset with E high in LINE1 (pulse for char 4).
        lcd_data = fa; frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0; ev_q.delete();
        n = 0;
        while (!(ev_q.size() >= 6 && lcd_e === 1'b1) && n < 100) begin @(negedge clk); n++; end
        check("e_high_before_rst", lcd_e, 1'b1);
        check("line1_char4_db", lcd_db, fa[39:32]);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_e", lcd_e, 1'b0);
        check("midrst_ready", frame_ready, 1'b0);
        check("midrst_init_done", init_done, 1'b0);
        rst = 1'b0;
        k = cyc; ev_q.delete();
        run_init(k);
        check("rw_always_low", rw_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
